// File: rtl/isqrt_pkg.sv
// Shared types and widths for the sequential integer square-root unit.
// Working remainder carries two guard bits above the final remainder width.
package isqrt_pkg;

  localparam int ROOT_W = 6;
  localparam int OP_W   = 2 * ROOT_W;
  localparam int REM_W  = ROOT_W + 1;
  localparam int RW_W   = ROOT_W + 3;
  localparam int CNT_W  = $clog2(ROOT_W);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/isqrt_step.sv
// One restoring square-root iteration: append the next operand bit pair to the
// remainder and try subtracting (Q<<2)|1; the root gains a 1 when it fits.
module isqrt_step #(
  parameter int ROOT_W = 6
) (
  input  logic [ROOT_W+2:0] i_r,
  input  logic [ROOT_W-1:0] i_q,
  input  logic [1:0]        i_bits,
  output logic [ROOT_W+2:0] o_r,
  output logic [ROOT_W-1:0] o_q
);
  import isqrt_pkg::*;

  logic [ROOT_W+2:0] w_r_sh;
  logic [ROOT_W+2:0] w_t;
  logic              w_ge;

  // Top two remainder bits are always zero here, so the shift loses nothing.
  assign w_r_sh = {i_r[ROOT_W:0], i_bits};
  assign w_t    = {1'b0, i_q, 2'b01};
  assign w_ge   = (w_r_sh >= w_t);
  assign o_r    = w_ge ? (w_r_sh - w_t) : w_r_sh;
  assign o_q    = {i_q[ROOT_W-2:0], w_ge};

endmodule

// File: rtl/isqrt_12bit.sv
// Sequential floor square root of a 2*ROOT_W-bit operand, one root bit per clock,
// with a start/done handshake and registered result outputs.
module isqrt_12bit #(
  parameter int ROOT_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2*ROOT_W-1:0]   p,
  output logic                  busy,
  output logic                  done,
  output logic [ROOT_W-1:0]     root,
  output logic [ROOT_W:0]       rem
);
  import isqrt_pkg::*;

  localparam int CNT_BITS = $clog2(ROOT_W);

  state_t                r_state;
  state_t                w_next;
  logic                  w_accept;
  logic [2*ROOT_W-1:0]   r_op;
  logic [ROOT_W+2:0]     r_r;
  logic [ROOT_W-1:0]     r_q;
  logic [CNT_BITS-1:0]   r_cnt;
  logic                  r_busy;
  logic                  r_done;
  logic [ROOT_W-1:0]     r_root;
  logic [ROOT_W:0]       r_rem;
  logic [ROOT_W+2:0]     w_r_next;
  logic [ROOT_W-1:0]     w_q_next;

  isqrt_step #(.ROOT_W(ROOT_W)) u_step (
    .i_r    (r_r),
    .i_q    (r_q),
    .i_bits (r_op[2*ROOT_W-1 -: 2]),
    .o_r    (w_r_next),
    .o_q    (w_q_next)
  );

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next   = ST_CALC;
          w_accept = 1'b1;
        end
      end
      ST_CALC: begin
        if (r_cnt == '0) w_next = ST_DONE;
      end
      ST_DONE: begin
        w_next = ST_IDLE;
        if (start) begin
          w_next   = ST_CALC;
          w_accept = 1'b1;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_op    <= '0;
      r_r     <= '0;
      r_q     <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_root  <= '0;
      r_rem   <= '0;
    end else begin
      r_state <= w_next;
      // Status flags follow the next state so they stay purely registered.
      r_busy  <= (w_next == ST_CALC);
      r_done  <= (w_next == ST_DONE);
      if (w_accept) begin
        r_op  <= p;
        r_r   <= '0;
        r_q   <= '0;
        r_cnt <= CNT_BITS'(ROOT_W - 1);
      end else if (r_state == ST_CALC) begin
        r_op  <= {r_op[2*ROOT_W-3:0], 2'b00};
        r_r   <= w_r_next;
        r_q   <= w_q_next;
        r_cnt <= r_cnt - 1'b1;
        if (r_cnt == '0) begin
          r_root <= w_q_next;
          r_rem  <= w_r_next[ROOT_W:0];
        end
      end
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign root = r_root;
  assign rem  = r_rem;

  a_rem_guard_zero : assert property (@(posedge clk) disable iff (rst)
    (r_state == ST_CALC && r_cnt == '0) |-> (w_r_next[ROOT_W+2:ROOT_W+1] == 2'b00));

endmodule
